// File: rtl/dds_pkg.sv
// Shared constants, register map, commit FSM states and LFSR helpers for the
// DDS phase generator.
package dds_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 12;
  localparam int NCH_DEF    = 4;

  localparam logic [2:0] REG_FTW  = 3'd0;
  localparam logic [2:0] REG_OFS0 = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd5;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } dds_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form (taps 0,2,3,5)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/dds_cfg_shadow.sv
// Shadow register bank, config write handshake and commit FSM. Writes only
// touch the shadow copy; the active copy is loaded in one shot on APPLY so
// every channel changes on the same clock edge.
module dds_cfg_shadow
  import dds_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEF,
  parameter int               NCH         = NCH_DEF,
  parameter logic [ACC_W-1:0] DEF_FTW     = ACC_W'(32'h0100_0000),
  parameter bit               DEF_EN      = 1'b1,
  parameter bit               SYNC_COMMIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2:0]           cfg_addr,
  input  logic [ACC_W-1:0]     cfg_data,
  input  logic                 commit,
  input  logic                 wrap,
  output logic                 busy,
  output logic [ACC_W-1:0]     act_ftw,
  output logic [NCH*ACC_W-1:0] act_ofs,
  output logic                 act_en,
  output logic                 apply_clr
);

  dds_state_e state_q, state_d;

  logic [ACC_W-1:0]     shd_ftw_q, shd_ftw_d;
  logic [NCH*ACC_W-1:0] shd_ofs_q, shd_ofs_d;
  logic                 shd_en_q, shd_en_d;
  logic                 shd_clr_q, shd_clr_d;
  logic [ACC_W-1:0]     act_ftw_q, act_ftw_d;
  logic [NCH*ACC_W-1:0] act_ofs_q, act_ofs_d;
  logic                 act_en_q, act_en_d;
  logic                 wr_en;

  assign cfg_ready = (state_q == IDLE) && !rst;
  assign wr_en     = cfg_valid && cfg_ready;
  assign busy      = (state_q != IDLE);
  assign apply_clr = (state_q == APPLY) && shd_clr_q;
  assign act_ftw   = act_ftw_q;
  assign act_ofs   = act_ofs_q;
  assign act_en    = act_en_q;

  // Commit sequencing: wait for a wrap (or go straight through) then apply for one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit) state_d = PENDING;
      PENDING: if (!SYNC_COMMIT || wrap || !act_en_q) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow writes from the config port and shadow-to-active transfer on APPLY
  always_comb begin
    shd_ftw_d = shd_ftw_q;
    shd_ofs_d = shd_ofs_q;
    shd_en_d  = shd_en_q;
    shd_clr_d = shd_clr_q;
    act_ftw_d = act_ftw_q;
    act_ofs_d = act_ofs_q;
    act_en_d  = act_en_q;
    if (wr_en) begin
      if (cfg_addr == REG_FTW) shd_ftw_d = cfg_data;
      if (cfg_addr == REG_CTRL) begin
        shd_en_d  = cfg_data[CTRL_EN_BIT];
        shd_clr_d = cfg_data[CTRL_CLR_BIT];
      end
      for (int k = 0; k < NCH; k++) begin
        if (int'(cfg_addr) == int'(REG_OFS0) + k) shd_ofs_d[k*ACC_W +: ACC_W] = cfg_data;
      end
    end
    if (state_q == APPLY) begin
      act_ftw_d = shd_ftw_q;
      act_ofs_d = shd_ofs_q;
      act_en_d  = shd_en_q;
      shd_clr_d = 1'b0;
    end
  end

  // State and register bank flops; reset abandons any pending commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shd_ftw_q <= DEF_FTW;
      shd_ofs_q <= '0;
      shd_en_q  <= DEF_EN;
      shd_clr_q <= 1'b0;
      act_ftw_q <= DEF_FTW;
      act_ofs_q <= '0;
      act_en_q  <= DEF_EN;
    end else begin
      state_q   <= state_d;
      shd_ftw_q <= shd_ftw_d;
      shd_ofs_q <= shd_ofs_d;
      shd_en_q  <= shd_en_d;
      shd_clr_q <= shd_clr_d;
      act_ftw_q <= act_ftw_d;
      act_ofs_q <= act_ofs_d;
      act_en_q  <= act_en_d;
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase generator: 32-bit phase accumulator plus per-channel offsets,
// truncated to LUT addresses for the four-channel sine lookup.
// Optional macro DDS_PHASE_DITHER_EN adds a shared LFSR dither below the
// truncation point; without it the phase is plainly truncated.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEF,
  parameter int               ADDR_W      = ADDR_W_DEF,
  parameter int               NCH         = NCH_DEF,
  parameter logic [ACC_W-1:0] DEF_FTW     = ACC_W'(32'h0100_0000),
  parameter bit               DEF_EN      = 1'b1,
  parameter bit               SYNC_COMMIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_addr,
  input  logic [ACC_W-1:0]      cfg_data,
  input  logic                  commit,
  output logic                  busy,
  output logic                  wrap,
  output logic                  ph_valid,
  output logic [NCH*ADDR_W-1:0] ph_out
);

  logic [ACC_W-1:0]      act_ftw;
  logic [NCH*ACC_W-1:0]  act_ofs;
  logic                  act_en;
  logic                  apply_clr;

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  wrap_q, wrap_d;
  logic [NCH*ADDR_W-1:0] ph_out_q, ph_out_d;
  logic                  ph_valid_q, ph_valid_d;
  logic [ACC_W:0]        acc_sum;
  logic [ACC_W-1:0]      phase_k;
  logic [ACC_W-1:0]      dither;

  dds_cfg_shadow #(
    .ACC_W       (ACC_W),
    .NCH         (NCH),
    .DEF_FTW     (DEF_FTW),
    .DEF_EN      (DEF_EN),
    .SYNC_COMMIT (SYNC_COMMIT)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .commit    (commit),
    .wrap      (wrap_q),
    .busy      (busy),
    .act_ftw   (act_ftw),
    .act_ofs   (act_ofs),
    .act_en    (act_en),
    .apply_clr (apply_clr)
  );

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITH_W = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;

  logic [15:0] lfsr_q, lfsr_d;

  // Dither LFSR advances only while the accumulator is running
  always_comb begin
    lfsr_d = act_en ? lfsr_next(lfsr_q) : lfsr_q;
  end

  // Dither LFSR state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign dither = {{(ACC_W-DITH_W){1'b0}}, lfsr_q[DITH_W-1:0]};
`else
  assign dither = '0;
`endif

  // Accumulator step: clear on a commit that requests it, otherwise advance when enabled
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, act_ftw};
    acc_d   = acc_q;
    wrap_d  = 1'b0;
    if (apply_clr) begin
      acc_d = '0;
    end else if (act_en) begin
      acc_d  = acc_sum[ACC_W-1:0];
      wrap_d = acc_sum[ACC_W];
    end
  end

  // Per-channel phase: accumulator plus offset, truncated to the LUT address
  always_comb begin
    ph_out_d   = '0;
    phase_k    = '0;
    ph_valid_d = act_en;
    for (int k = 0; k < NCH; k++) begin
      phase_k = acc_q + act_ofs[k*ACC_W +: ACC_W] + dither;
      ph_out_d[k*ADDR_W +: ADDR_W] = phase_k[ACC_W-1 -: ADDR_W];
    end
  end

  // Accumulator and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      wrap_q     <= 1'b0;
      ph_out_q   <= '0;
      ph_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      wrap_q     <= wrap_d;
      ph_out_q   <= ph_out_d;
      ph_valid_q <= ph_valid_d;
    end
  end

  assign wrap     = wrap_q;
  assign ph_out   = ph_out_q;
  assign ph_valid = ph_valid_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: two instances (commit on wrap / commit immediately)
// share one stimulus stream and are compared every cycle with a behavioural model.
module tb_dds_phase_gen;

  localparam int NCH    = 4;
  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        commit;

  logic                  rdy_w   [2];
  logic                  busy_w  [2];
  logic                  wrap_w  [2];
  logic                  valid_w [2];
  logic [NCH*ADDR_W-1:0] ph_w    [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model state, index 0 = commit-on-wrap, index 1 = immediate commit
  logic [31:0] m_acc [2];
  logic [31:0] m_ftw [2];
  logic [31:0] s_ftw [2];
  logic [31:0] m_ofs [2][NCH];
  logic [31:0] s_ofs [2][NCH];
  bit          m_en [2], s_en [2], s_clr [2];
  bit          m_wrap [2], m_valid [2], m_pending [2], m_applying [2];
  logic [11:0] m_ph [2][NCH];

  always #5 clk = ~clk;

  dds_phase_gen #(.SYNC_COMMIT(1'b1)) dut_sync (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy_w[0]),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .commit(commit),
    .busy(busy_w[0]), .wrap(wrap_w[0]), .ph_valid(valid_w[0]), .ph_out(ph_w[0])
  );

  dds_phase_gen #(.SYNC_COMMIT(1'b0)) dut_imm (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy_w[1]),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .commit(commit),
    .busy(busy_w[1]), .wrap(wrap_w[1]), .ph_valid(valid_w[1]), .ph_out(ph_w[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_ftw[i] = 32'h0100_0000; s_ftw[i] = 32'h0100_0000;
      m_en[i] = 1; s_en[i] = 1; s_clr[i] = 0;
      m_wrap[i] = 0; m_valid[i] = 0; m_pending[i] = 0; m_applying[i] = 0;
      for (int k = 0; k < NCH; k++) begin
        m_ofs[i][k] = 0; s_ofs[i][k] = 0; m_ph[i][k] = 0;
      end
    end
  endtask

  // One clock of the reference: everything below reads the pre-edge model state
  task automatic modelStep(input int i);
    bit          accepting;
    bit          go_apply;
    bit          prev_wrap;
    longint      total;
    logic [31:0] p;
    accepting = !m_pending[i] && !m_applying[i];
    prev_wrap = m_wrap[i];
    for (int k = 0; k < NCH; k++) begin
      p = m_acc[i] + m_ofs[i][k];
      m_ph[i][k] = p[31:20];
    end
    m_valid[i] = m_en[i];
    total = longint'(m_acc[i]) + longint'(m_ftw[i]);
    if (m_applying[i] && s_clr[i]) begin
      m_acc[i] = 0; m_wrap[i] = 0;
    end else if (m_en[i]) begin
      m_acc[i] = total[31:0]; m_wrap[i] = (total >= 64'h1_0000_0000);
    end else begin
      m_wrap[i] = 0;
    end
    go_apply = m_pending[i] && ((i == 1) || prev_wrap || !m_en[i]);
    if (m_applying[i]) begin
      m_ftw[i] = s_ftw[i]; m_en[i] = s_en[i]; s_clr[i] = 0;
      for (int k = 0; k < NCH; k++) m_ofs[i][k] = s_ofs[i][k];
      m_applying[i] = 0;
    end else if (go_apply) begin
      m_pending[i] = 0; m_applying[i] = 1;
    end else if (accepting && commit) begin
      m_pending[i] = 1;
    end
    if (accepting && cfg_valid) begin
      if (cfg_addr == 0) s_ftw[i] = cfg_data;
      else if (cfg_addr >= 1 && cfg_addr <= 4) s_ofs[i][cfg_addr-1] = cfg_data;
      else if (cfg_addr == 5) begin s_en[i] = cfg_data[0]; s_clr[i] = cfg_data[1]; end
    end
  endtask

  // Per-cycle compare of both instances against the model, 1 time unit after the edge
  always @(posedge clk) begin
    if (rst) modelReset();
    else begin modelStep(0); modelStep(1); end
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NCH; k++)
        checkOutput($sformatf("inst%0d ph_out ch%0d", i, k), 32'(ph_w[i][k*ADDR_W +: ADDR_W]), 32'(m_ph[i][k]));
      checkOutput($sformatf("inst%0d ph_valid", i), 32'(valid_w[i]), 32'(m_valid[i]));
      checkOutput($sformatf("inst%0d wrap", i), 32'(wrap_w[i]), 32'(m_wrap[i]));
      checkOutput($sformatf("inst%0d busy", i), 32'(busy_w[i]), 32'(m_pending[i] || m_applying[i]));
      checkOutput($sformatf("inst%0d cfg_ready", i), 32'(rdy_w[i]), 32'(!rst && !m_pending[i] && !m_applying[i]));
    end
  end

  task automatic applyStimulus(input bit v, input logic [2:0] a, input logic [31:0] d, input bit c);
    @(negedge clk);
    cfg_valid = v; cfg_addr = a; cfg_data = d; commit = c;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waitIdle timeout", 32'(n >= limit), 32'd0);
  endtask

  task automatic checkRamp(input string tag);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        checkOutput($sformatf("%s inst%0d ch0 step %0d", tag, i, j), 32'(ph_w[i][11:0]), 32'(j * 16));
      if (j == 0) checkOutput({tag, " ph_valid first edge"}, 32'(valid_w[0]), 32'd1);
    end
  endtask

  logic [11:0] prev_ph;

  initial begin
    rst = 1'b1; cfg_valid = 0; cfg_addr = 0; cfg_data = 0; commit = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkRamp("release");

    // ch1 offset of a quarter turn, committed together with the write
    applyStimulus(1, 3'd2, 32'h4000_0000, 1);
    @(posedge clk); #1 checkOutput("imm busy cycle1", 32'(busy_w[1]), 32'd1);
    applyStimulus(0, 3'd0, 32'h0, 0);
    @(posedge clk); #1 checkOutput("imm busy cycle2", 32'(busy_w[1]), 32'd1);
    @(posedge clk); #1 checkOutput("imm busy done", 32'(busy_w[1]), 32'd0);
    checkOutput("sync still pending", 32'(rdy_w[0]), 32'd0);
    waitIdle(600);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("inst%0d ch1-ch0", i), 32'((ph_w[i][23:12] - ph_w[i][11:0]) & 12'hFFF), 32'h400);

    // Double the tuning word
    applyStimulus(1, 3'd0, 32'h0200_0000, 0);
    applyStimulus(0, 3'd0, 32'h0, 1);
    applyStimulus(0, 3'd0, 32'h0, 0);
    waitIdle(600);
    @(posedge clk); #1 prev_ph = ph_w[1][11:0];
    @(posedge clk); #1 checkOutput("imm step after ftw x2", 32'((ph_w[1][11:0] - prev_ph) & 12'hFFF), 32'h020);

    // Half-turn FTW with accumulator clear, ctrl write in the commit cycle
    applyStimulus(1, 3'd0, 32'h8000_0000, 0);
    applyStimulus(1, 3'd5, 32'h3, 1);
    applyStimulus(0, 3'd0, 32'h0, 0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 checkOutput("imm ch0 after clr", 32'(ph_w[1][11:0]), 32'h000);
    @(posedge clk); #1 checkOutput("imm ch0 half turn", 32'(ph_w[1][11:0]), 32'h800);
    checkOutput("imm wrap half turn", 32'(wrap_w[1]), 32'd1);
    @(posedge clk); #1 checkOutput("imm ch0 back to zero", 32'(ph_w[1][11:0]), 32'h000);
    waitIdle(600);

    // Second commit without writes: the clear must not repeat
    applyStimulus(0, 3'd0, 32'h0, 1);
    applyStimulus(0, 3'd0, 32'h0, 0);
    waitIdle(600);

    // Randomized traffic, enable kept mostly on so commits on wrap resolve
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd5) d[0] = ($urandom_range(0, 4) != 0);
      applyStimulus($urandom_range(0, 3) == 0, a, d, $urandom_range(0, 9) == 0);
    end
    applyStimulus(0, 3'd0, 32'h0, 0);
    waitIdle(5000);

    // Reset in the middle of a commit
    applyStimulus(1, 3'd0, 32'h1000_0000, 1);
    applyStimulus(0, 3'd0, 32'h0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("inst%0d ph_out in reset", i), 32'(ph_w[i] != 0), 32'd0);
      checkOutput($sformatf("inst%0d ph_valid in reset", i), 32'(valid_w[i]), 32'd0);
      checkOutput($sformatf("inst%0d busy in reset", i), 32'(busy_w[i]), 32'd0);
      checkOutput($sformatf("inst%0d cfg_ready in reset", i), 32'(rdy_w[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("sync cfg_ready after reset", 32'(rdy_w[0]), 32'd1);
    checkRamp("re-release");
    repeat (4) @(posedge clk);
    #2;
    checkOutput("busy after reset", 32'(busy_w[0] || busy_w[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dds_phase_gen.md
Name: dds_phase_gen

Overview:
- Programmable phase-generation stage directly upstream of the four-channel sine lookup.
- A 32-bit phase accumulator advances by a frequency tuning word (FTW) every clk.
- Four per-channel phase offsets produce four truncated LUT addresses, one per DAC channel.
- Configuration is written into shadow registers and committed atomically, so all channels change frequency/phase together without glitches.

Parameters:
- ACC_W, 32, accumulator and offset width
- ADDR_W, 12, LUT address width per channel (top ADDR_W bits of phase)
- NCH, 4, number of phase channels
- DEF_FTW, 32'h0100_0000, active/shadow FTW after reset
- DEF_EN, 1, accumulator enable after reset
- SYNC_COMMIT, 1, 1 = apply commit on the next accumulator wrap; 0 = apply immediately

Ports:
- clk  in  1  system/DAC clock
- rst  in  1  reset; asynchronous, active-high
- cfg_valid  in  1  config write strobe
- cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready
- cfg_addr  in  3  register select: 0 FTW; 1..4 offset ch0..ch3; 5 control (bit0 enable, bit1 clear-acc)
- cfg_data  in  32  write data
- commit  in  1  single-cycle request to load shadow into active registers
- busy  out  1  commit pending or applying
- wrap  out  1  one-cycle pulse on accumulator carry-out
- ph_valid  out  1  ph_out holds valid phases
- ph_out  out  NCH*ADDR_W  channel k at bits [k*ADDR_W +: ADDR_W]

Behaviour:
- Reset (async, rst=1):
  - acc=0.
  - Active and shadow FTW = DEF_FTW; all offsets = 0; enable = DEF_EN; clr bit = 0.
  - FSM = IDLE.
  - ph_out=0, ph_valid=0, wrap=0, busy=0.
  - cfg_ready is forced 0 while rst=1; writes are ignored during reset.
- Accumulator:
  - If active enable: acc <= (acc + ftw) mod 2^ACC_W.
  - wrap <= carry-out of that add (registered, aligned with the new acc).
  - If disabled: acc holds and wrap=0.
- Phase path:
  - Each clk: p_k = (acc + ofs_k) mod 2^ACC_W; ph_out_k <= p_k[ACC_W-1 -: ADDR_W].
  - ph_valid <= active enable.
  - Latency: ph_out reflects the acc value present at the previous edge, so the first valid sample after reset release is 0.
- Config handshake:
  - A write occurs when cfg_valid && cfg_ready. It updates shadow registers only.
  - Writes to addresses 6 and 7 are accepted and discarded.
  - cfg_ready = 1 only in IDLE.
- FSM:
  - IDLE -> PENDING on commit. A write in the same cycle as commit is included in that commit.
  - PENDING -> APPLY when SYNC_COMMIT==0, or wrap==1, or active enable==0.
  - APPLY (one cycle) -> IDLE.
  - At the APPLY edge: active FTW, offsets and enable <= shadow. If shadow clr=1, acc <= 0 instead of advancing, and shadow clr self-clears.
  - Otherwise acc advances with the old FTW at the APPLY edge; the new FTW takes effect from the following edge.
- busy = (state != IDLE).
- commit while PENDING/APPLY is ignored (no queueing).
- Reset mid-PENDING/APPLY: the pending commit is abandoned and all shadow and active registers return to defaults.
- Arithmetic: all adds are modulo 2^ACC_W; carries beyond ACC_W are dropped except the acc carry used for wrap.

Optional Feature:
- Macro: DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) steps every clk.
  - Its low min(16, ACC_W-ADDR_W) bits are added to each p_k before truncation (mod 2^ACC_W). All channels share the same LFSR value.
  - The LFSR holds while active enable=0.
- Not defined: plain truncation; no LFSR logic is instantiated.

Decomposition:
- Package dds_pkg contains:
  - ACC_W/ADDR_W/NCH defaults
  - register address constants (REG_FTW=0, REG_OFS0=1, REG_CTRL=5)
  - control bit indices
  - FSM state enum (IDLE, PENDING, APPLY)
  - LFSR seed/taps
- Sub-module dds_cfg_shadow: shadow register bank, handshake and commit FSM; outputs the active registers and busy.
- The accumulator and phase adders stay in the top.

Test Plan:
- Reset release, defaults, SYNC_COMMIT=1 -> ch0 ph_out sequence 0x000, 0x010, 0x020, ...; ph_valid=1 from the first edge after release; all channels equal.
- Write ofs ch1=32'h4000_0000, commit, SYNC_COMMIT=0 -> busy for 2 cycles; afterwards ch1 = (ch0 + 0x400) mod 4096 every cycle.
- SYNC_COMMIT=1, write FTW=32'h0200_0000, commit mid-cycle of the accumulator period -> cfg_ready=0 until wrap; step stays 0x010 until the edge after APPLY, then 0x020.
- FTW=32'h8000_0000 committed -> wrap pulses every 2nd cycle; ch0 alternates 0x000/0x800.
- Write ctrl=2'b11, commit -> acc=0 at the APPLY edge; ch0=0x000 on the next sample; ctrl readback effect: clr does not repeat on the next commit.
- Assert rst for 1 cycle while busy=1 -> all outputs 0 immediately; after release FTW=DEF_FTW, offsets 0, cfg_ready=1, pending commit lost.
